// File: rtl/vram_pkg.sv
// Shared types and constants for the VRAM arbiter: access-owner tags, FSM states, default widths
// and the fixed scanout fetch latency.
package vram_pkg;
  localparam int AW_DEF   = 16;
  localparam int DW_DEF   = 8;
  localparam int DISP_LAT = 3;

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_DISP = 2'd1,
    TAG_HOST = 2'd2
  } tag_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DISP = 2'd1,
    ST_HOST = 2'd2
  } state_e;
endpackage

// File: rtl/vram_post_fifo.sv
// Two-entry host write-posting FIFO holding {addr, wdata}; used only when VRAM_HOST_POST_EN is defined.
module vram_post_fifo #(
  parameter int AW = 16,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [AW-1:0] push_addr,
  input  logic [DW-1:0] push_wdata,
  input  logic          pop,
  output logic [AW-1:0] head_addr,
  output logic [DW-1:0] head_wdata,
  output logic          full,
  output logic          empty
);
  logic [AW+DW-1:0] mem_q [2];
  logic [AW+DW-1:0] mem_d [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == 2'd2);
  assign empty   = (count_q == 2'd0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign {head_addr, head_wdata} = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = {push_addr, push_wdata};
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (do_pop) rd_ptr_d = ~rd_ptr_q;
    count_d = count_q + 2'(do_push) - 2'(do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: scanout fetch has absolute priority, the host gets the remaining slots.
// Define VRAM_HOST_POST_EN to add a 2-entry host write-posting FIFO.
module vram_arbiter #(
  parameter int AW       = vram_pkg::AW_DEF,
  parameter int DW       = vram_pkg::DW_DEF,
  parameter int DISP_LAT = vram_pkg::DISP_LAT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          disp_req,
  input  logic [AW-1:0] disp_addr,
  output logic [DW-1:0] disp_data,
  output logic          disp_valid,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic          host_gnt,
  output logic [DW-1:0] host_rdata,
  output logic          host_rvalid,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          disp_overrun,
  output logic [1:0]    dbg_state
);
  import vram_pkg::*;

  localparam int TAGS = DISP_LAT - 1;

  state_e        state_q, state_d;
  logic          disp_pend_q, disp_pend_d;
  logic [AW-1:0] disp_addr_q, disp_addr_d;
  logic          overrun_q, overrun_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic          mem_we_q, mem_we_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  tag_e          tag_q [TAGS];
  tag_e          tag_d [TAGS];
  logic [DW-1:0] disp_data_q, disp_data_d;
  logic          disp_valid_q, disp_valid_d;
  logic [DW-1:0] host_rdata_q, host_rdata_d;
  logic          host_rvalid_q, host_rvalid_d;
  logic          host_gnt_q, host_gnt_d;

  // Host access source for the next HOST slot: the port itself or the posting FIFO head.
  logic          host_pend;
  logic          host_src_we;
  logic          host_src_is_fifo;
  logic [AW-1:0] host_src_addr;
  logic [DW-1:0] host_src_wdata;

`ifdef VRAM_HOST_POST_EN
  logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [AW-1:0] fifo_addr;
  logic [DW-1:0] fifo_wdata;

  assign fifo_push = rst_n && host_req && host_we && !fifo_full;
  assign fifo_pop  = (state_d == ST_HOST) && !fifo_empty;

  vram_post_fifo #(.AW(AW), .DW(DW)) u_post_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (fifo_push),
    .push_addr  (host_addr),
    .push_wdata (host_wdata),
    .pop        (fifo_pop),
    .head_addr  (fifo_addr),
    .head_wdata (fifo_wdata),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  // Reads wait for the FIFO to drain so they observe every earlier posted write.
  assign host_pend        = !fifo_empty || (host_req && !host_we);
  assign host_src_is_fifo = !fifo_empty;
  assign host_src_we      = !fifo_empty;
  assign host_src_addr    = fifo_empty ? host_addr : fifo_addr;
  assign host_src_wdata   = fifo_wdata;
  assign host_gnt         = host_gnt_q || fifo_push;
`else
  assign host_pend        = host_req;
  assign host_src_is_fifo = 1'b0;
  assign host_src_we      = host_we;
  assign host_src_addr    = host_addr;
  assign host_src_wdata   = host_wdata;
  assign host_gnt         = host_gnt_q;
`endif

  // A display issue is never followed directly by another one, so the second of two
  // back-to-back strobes waits a slot and a third strobe in a row is an overrun.
  always_comb begin
    state_d = ST_IDLE;
    if (disp_pend_q && state_q != ST_DISP)
      state_d = ST_DISP;
    else if (host_pend && !disp_req && state_q != ST_HOST)
      state_d = ST_HOST;

    disp_pend_d = (disp_pend_q && state_d != ST_DISP) || disp_req;
    disp_addr_d = disp_req ? disp_addr : disp_addr_q;
    overrun_d   = overrun_q || (disp_req && disp_pend_q && state_d != ST_DISP);
    host_gnt_d  = (state_d == ST_HOST) && !host_src_is_fifo;

    mem_addr_d  = mem_addr_q;
    mem_we_d    = 1'b0;
    mem_wdata_d = mem_wdata_q;
    tag_d[0]    = TAG_NONE;
    for (int i = 1; i < TAGS; i++) tag_d[i] = tag_q[i-1];
    case (state_d)
      ST_DISP: begin
        mem_addr_d = disp_addr_q;
        tag_d[0]   = TAG_DISP;
      end
      ST_HOST: begin
        mem_addr_d = host_src_addr;
        mem_we_d   = host_src_we;
        if (host_src_we) mem_wdata_d = host_src_wdata;
        else             tag_d[0]    = TAG_HOST;
      end
      default: ;
    endcase

    disp_valid_d  = (tag_q[TAGS-1] == TAG_DISP);
    disp_data_d   = disp_valid_d ? mem_rdata : disp_data_q;
    host_rvalid_d = (tag_q[TAGS-1] == TAG_HOST);
    host_rdata_d  = host_rvalid_d ? mem_rdata : host_rdata_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      disp_pend_q   <= 1'b0;
      disp_addr_q   <= '0;
      overrun_q     <= 1'b0;
      mem_addr_q    <= '0;
      mem_we_q      <= 1'b0;
      mem_wdata_q   <= '0;
      for (int i = 0; i < TAGS; i++) tag_q[i] <= TAG_NONE;
      disp_data_q   <= '0;
      disp_valid_q  <= 1'b0;
      host_rdata_q  <= '0;
      host_rvalid_q <= 1'b0;
      host_gnt_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      disp_pend_q   <= disp_pend_d;
      disp_addr_q   <= disp_addr_d;
      overrun_q     <= overrun_d;
      mem_addr_q    <= mem_addr_d;
      mem_we_q      <= mem_we_d;
      mem_wdata_q   <= mem_wdata_d;
      tag_q         <= tag_d;
      disp_data_q   <= disp_data_d;
      disp_valid_q  <= disp_valid_d;
      host_rdata_q  <= host_rdata_d;
      host_rvalid_q <= host_rvalid_d;
      host_gnt_q    <= host_gnt_d;
    end
  end

  assign disp_data    = disp_data_q;
  assign disp_valid   = disp_valid_q;
  assign host_rdata   = host_rdata_q;
  assign host_rvalid  = host_rvalid_q;
  assign mem_addr     = mem_addr_q;
  assign mem_we       = mem_we_q;
  assign mem_wdata    = mem_wdata_q;
  assign disp_overrun = overrun_q;
  assign dbg_state    = state_q;
endmodule
